pwm_deadtime: RTL

- Downstream stage of the PWM peripheral: consumes each `pwm_out`/`pwm_en` pair and drives complementary high-side/low-side gate signals.
- Inserts programmable dead time between the two sides so they are never on together.
- Includes a latched fault shutdown shared by all channels.
- Sits between the PWM peripheral outputs and the GPIO/pad mux.

---
 rtl/pwm_deadtime_pkg.sv | 16 +
 rtl/pwm_deadtime_channel.sv | 135 +++++++++++++
 rtl/pwm_deadtime.sv | 74 +++++++
 3 files changed

// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the complementary-output dead-time stage:
// per-channel FSM state encoding and default sizing constants.
package pwm_deadtime_pkg;

  localparam int DEAD_WIDTH_DEFAULT = 8;
  localparam int CHANNELS_DEFAULT   = 16;

  typedef enum logic [2:0] {
    DT_OFF          = 3'd0,
    DT_DEAD_TO_HIGH = 3'd1,
    DT_HIGH_ON      = 3'd2,
    DT_DEAD_TO_LOW  = 3'd3,
    DT_LOW_ON       = 3'd4
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime_channel.sv
// One complementary output pair: state machine plus dead-time down-counter.
// Raw high/low are registered and can never be asserted together.
module pwm_deadtime_channel
  import pwm_deadtime_pkg::*;
#(
  parameter int DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm,
  input  logic                  en,
  input  logic                  force_off,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  output logic                  high,
  output logic                  low_raw
);

  dt_state_e             state_q, state_d;
  logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  from_on_q, from_on_d;
  logic                  high_q, high_d;
  logic                  low_q, low_d;
  logic                  req_high, req_low;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    from_on_d = from_on_q;
    req_high  = 1'b0;
    req_low   = 1'b0;
    if (force_off || !en) begin
      state_d   = DT_OFF;
      cnt_d     = '0;
      from_on_d = 1'b0;
    end else begin
      case (state_q)
        DT_OFF: begin
          from_on_d = 1'b0;
          if (pwm) req_high = 1'b1;
          else     req_low  = 1'b1;
        end
        DT_HIGH_ON: begin
          if (!pwm) begin
            req_low   = 1'b1;
            from_on_d = 1'b1;
          end
        end
        DT_LOW_ON: begin
          if (pwm) begin
            req_high  = 1'b1;
            from_on_d = 1'b1;
          end
        end
        DT_DEAD_TO_HIGH: begin
          // A glitch only snaps straight back if the low side was actually on
          // before; coming out of OFF it must wait out a fresh dead time.
          if (!pwm) begin
            if (from_on_q) begin
              state_d = DT_LOW_ON;
              cnt_d   = '0;
            end else begin
              req_low = 1'b1;
            end
          end else if (cnt_q <= DEAD_WIDTH'(1)) begin
            state_d = DT_HIGH_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DEAD_WIDTH'(1);
          end
        end
        DT_DEAD_TO_LOW: begin
          if (pwm) begin
            if (from_on_q) begin
              state_d = DT_HIGH_ON;
              cnt_d   = '0;
            end else begin
              req_high = 1'b1;
            end
          end else if (cnt_q <= DEAD_WIDTH'(1)) begin
            state_d = DT_LOW_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DEAD_WIDTH'(1);
          end
        end
        default: begin
          state_d = DT_OFF;
          cnt_d   = '0;
        end
      endcase

      // Zero dead time bypasses the DEAD states entirely.
      if (req_high) begin
        if (dead_time == '0) begin
          state_d = DT_HIGH_ON;
          cnt_d   = '0;
        end else begin
          state_d = DT_DEAD_TO_HIGH;
          cnt_d   = dead_time;
        end
      end
      if (req_low) begin
        if (dead_time == '0) begin
          state_d = DT_LOW_ON;
          cnt_d   = '0;
        end else begin
          state_d = DT_DEAD_TO_LOW;
          cnt_d   = dead_time;
        end
      end
    end
    high_d = (state_d == DT_HIGH_ON);
    low_d  = (state_d == DT_LOW_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DT_OFF;
      cnt_q     <= '0;
      from_on_q <= 1'b0;
      high_q    <= 1'b0;
      low_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      from_on_q <= from_on_d;
      high_q    <= high_d;
      low_q     <= low_d;
    end
  end

  assign high    = high_q;
  assign low_raw = low_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time insertion for all PWM channels, with a synchronised, latched
// fault shutdown shared by every channel and a registered pad output-enable.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int CHANNELS   = CHANNELS_DEFAULT,
  parameter int DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   pwm_in,
  input  logic [CHANNELS-1:0]   pwm_en_in,
  input  logic [DEAD_WIDTH-1:0] deadTime,
  input  logic [CHANNELS-1:0]   invertLow,
  input  logic                  fault,
  input  logic                  faultClear,
  output logic [CHANNELS-1:0]   gate_high,
  output logic [CHANNELS-1:0]   gate_low,
  output logic [CHANNELS-1:0]   gate_en,
  output logic                  faultActive
);

  logic                fault_meta_q, fault_meta_d;
  logic                fault_sync_q, fault_sync_d;
  logic                fault_active_q, fault_active_d;
  logic [CHANNELS-1:0] gate_en_q, gate_en_d;
  logic [CHANNELS-1:0] low_raw;

  always_comb begin
    fault_meta_d = fault;
    fault_sync_d = fault_meta_q;
    // A still-present fault beats a clear request.
    if (fault_sync_q)    fault_active_d = 1'b1;
    else if (faultClear) fault_active_d = 1'b0;
    else                 fault_active_d = fault_active_q;
    gate_en_d = pwm_en_in & {CHANNELS{~fault_active_d}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_meta_q   <= 1'b0;
      fault_sync_q   <= 1'b0;
      fault_active_q <= 1'b0;
      gate_en_q      <= '0;
    end else begin
      fault_meta_q   <= fault_meta_d;
      fault_sync_q   <= fault_sync_d;
      fault_active_q <= fault_active_d;
      gate_en_q      <= gate_en_d;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pwm_deadtime_channel #(
        .DEAD_WIDTH(DEAD_WIDTH)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst),
        .pwm      (pwm_in[gi]),
        .en       (pwm_en_in[gi]),
        .force_off(fault_active_d),
        .dead_time(deadTime),
        .high     (gate_high[gi]),
        .low_raw  (low_raw[gi])
      );
    end
  endgenerate

  assign gate_low    = low_raw ^ invertLow;
  assign gate_en     = gate_en_q;
  assign faultActive = fault_active_q;

endmodule
